// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and counter sizing.
package sequential_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned word_length);
    return $clog2(word_length + 1);
  endfunction

endpackage

// File: rtl/sequential_divider_step.sv
// One combinational restore step: shift {A,Q} left, trial-subtract D, restore on borrow.
module divider_step
  import sequential_divider_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 4
) (
  input  logic [WORD_LENGTH-1:0] a_i,
  input  logic [WORD_LENGTH-1:0] q_i,
  input  logic [WORD_LENGTH-1:0] d_i,
  output logic [WORD_LENGTH-1:0] a_o,
  output logic [WORD_LENGTH-1:0] q_o
);

  logic [WORD_LENGTH:0] shifted;
  logic [WORD_LENGTH:0] trial;

  always_comb begin
    // Keep the bit shifted out of A as a guard bit so the trial subtract cannot overflow.
    shifted = {a_i, q_i[WORD_LENGTH-1]};
    trial   = shifted - {1'b0, d_i};
    if (!trial[WORD_LENGTH]) begin
      a_o = trial[WORD_LENGTH-1:0];
    end else begin
      a_o = shifted[WORD_LENGTH-1:0];
    end
    q_o = {q_i[WORD_LENGTH-2:0], ~trial[WORD_LENGTH]};
  end

endmodule

// File: rtl/sequential_divider.sv
// Unsigned restoring divider, one quotient bit per clock, start/done handshake.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] dividend,
  input  logic [WORD_LENGTH-1:0] divisor,
  output logic [WORD_LENGTH-1:0] quotient,
  output logic [WORD_LENGTH-1:0] remainder,
  output logic                   busy,
  output logic                   done,
  output logic                   div_by_zero
);

  localparam int unsigned CW = cnt_width(WORD_LENGTH);

  state_t                 state_q;
  logic [WORD_LENGTH-1:0] a_q, q_q, d_q;
  logic [WORD_LENGTH-1:0] a_d, q_d;
  logic [CW-1:0]          cnt_q;
  logic [WORD_LENGTH-1:0] quotient_q, remainder_q;
  logic                   busy_q, done_q, dbz_q;

  divider_step #(.WORD_LENGTH(WORD_LENGTH)) u_step (
    .a_i(a_q),
    .q_i(q_q),
    .d_i(d_q),
    .a_o(a_d),
    .q_o(q_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (divisor != '0) begin
              a_q     <= '0;
              q_q     <= dividend;
              d_q     <= divisor;
              cnt_q   <= CW'(WORD_LENGTH);
              state_q <= S_CALC;
            end else begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quotient_q  <= q_d;
            remainder_q <= a_d;
            dbz_q       <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider (WORD_LENGTH=4): handshake, latency, corner cases, full sweep.
module tb_sequential_divider;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  int checks = 0;
  int errors = 0;

  sequential_divider #(.WORD_LENGTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts negedges until done is seen (bounded); 99 means it never came.
  task automatic wait_done(output int n);
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Issues a one-cycle start pulse from a negedge and returns the done latency.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int n);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom_range(15, 0);
    divisor  = $urandom_range(15, 0);
    wait_done(n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    logic [W-1:0] cap_q, cap_r;

    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    reset = 1'b1;
    @(negedge clk);

    // 13/3 with busy rise and 5-cycle latency
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(posedge clk);
    #1 start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    @(negedge clk);
    chk("13_3_busy_rise", busy, 1);
    chk("13_3_no_early_done", done, 0);
    wait_done(n);
    chk("13_3_latency", n + 1, 5);
    chk("13_3_q", quotient, 4);
    chk("13_3_r", remainder, 1);
    chk("13_3_dbz", div_by_zero, 0);
    chk("13_3_busy_in_done", busy, 1);
    @(negedge clk);
    chk("13_3_done_one_cycle", done, 0);
    chk("13_3_busy_fall", busy, 0);
    chk("13_3_q_held", quotient, 4);

    // 15/1 then 2/9 with start held high
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    wait_done(n);
    chk("15_1_latency", n, 5);
    chk("15_1_q", quotient, 15);
    chk("15_1_r", remainder, 0);
    dividend = 4'd2; divisor = 4'd9;
    @(negedge clk);
    chk("b2b_idle_gap_busy", busy, 0);
    chk("b2b_idle_gap_done", done, 0);
    @(negedge clk);
    chk("b2b_second_accept", busy, 1);
    start = 1'b0;
    wait_done(n);
    chk("2_9_latency", n + 1, 5);
    chk("2_9_q", quotient, 0);
    chk("2_9_r", remainder, 2);
    @(negedge clk);

    // 7/0 then 6/2
    issue(4'd7, 4'd0, n);
    chk("7_0_latency", n, 1);
    chk("7_0_q", quotient, 15);
    chk("7_0_r", remainder, 7);
    chk("7_0_dbz", div_by_zero, 1);
    @(negedge clk);
    chk("7_0_dbz_held", div_by_zero, 1);
    issue(4'd6, 4'd2, n);
    chk("6_2_latency", n, 5);
    chk("6_2_q", quotient, 3);
    chk("6_2_r", remainder, 0);
    chk("6_2_dbz", div_by_zero, 0);
    @(negedge clk);

    // 12/5 with an ignored 9/3 start during CALC
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0; cap_q = '0; cap_r = '0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 2) begin
        start = 1'b1; dividend = 4'd9; divisor = 4'd3;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        pulses++;
        cap_q = quotient;
        cap_r = remainder;
      end
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_q", cap_q, 2);
    chk("ign_r", cap_r, 2);

    // 14/4 aborted by asynchronous reset in CALC cycle 3
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dbz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    chk("abort_idle_busy", busy, 0);
    issue(4'd14, 4'd4, n);
    chk("14_4_latency", n, 5);
    chk("14_4_q", quotient, 3);
    chk("14_4_r", remainder, 2);
    @(negedge clk);

    // Full sweep against the completion invariant and divide-by-zero rule
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue(W'(a), W'(b), n);
        if (b == 0) begin
          chk($sformatf("sw_%0d_0_lat", a), n, 1);
          chk($sformatf("sw_%0d_0_q", a), quotient, 15);
          chk($sformatf("sw_%0d_0_r", a), remainder, a);
          chk($sformatf("sw_%0d_0_dbz", a), div_by_zero, 1);
        end else begin
          chk($sformatf("sw_%0d_%0d_lat", a, b), n, 5);
          chk($sformatf("sw_%0d_%0d_inv", a, b), 32'(quotient) * 32'(b) + 32'(remainder), a);
          chk($sformatf("sw_%0d_%0d_rlt", a, b), 32'(remainder < W'(b)), 1);
          chk($sformatf("sw_%0d_%0d_dbz", a, b), div_by_zero, 0);
        end
        @(negedge clk);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
